micro_seq: RTL and testbench

- Microprogram sequencer that owns the control address register (CAR) for the simple processor's control store.
- Each cycle it takes the next-address field of the current microinstruction, the datapath status flags and the instruction opcode, and registers the next control-store address.
- It supports sequential, jump, conditional branch, opcode dispatch, one-level-deep-per-entry call/return, halt, and fetch (return to address 0).
- It sits between the control ROM output and the control ROM address input. The datapath sees only the control words it selects.

---
 rtl/micro_seq.sv | 109 ++++++++++
 tb/tb_micro_seq.sv | 134 +++++++++++++
 2 files changed

// File: rtl/micro_seq.sv
// Microprogram sequencer: owns the control address register and a small
// return stack, selecting the next control-store address every cycle.
module micro_seq #(
   parameter int unsigned AW       = 8,
   parameter int unsigned MAP_BASE = 'h40,
   parameter int unsigned DEPTH    = 4
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [2:0]              NA_SEL,
   input  logic [2:0]              CS,
   input  logic                    POL,
   input  logic [AW-1:0]           BR_ADDR,
   input  logic [3:0]              OPCODE,
   input  logic [7:0]              COND,
   input  logic                    STALL,
   output logic [AW-1:0]           CAR,
   output logic                    HALTED,
   output logic                    STK_ERR,
   output logic [$clog2(DEPTH):0]  SP
);

   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned SW = IW + 1;

   typedef enum logic [2:0] {
      OP_NEXT  = 3'd0,
      OP_JMP   = 3'd1,
      OP_BR    = 3'd2,
      OP_MAP   = 3'd3,
      OP_CALL  = 3'd4,
      OP_RET   = 3'd5,
      OP_HALT  = 3'd6,
      OP_FETCH = 3'd7
   } na_op_e;

   na_op_e        op;
   logic          t;
   logic [AW-1:0] inc;
   logic [AW-1:0] map_addr;
   logic          full;
   logic          empty;
   logic          push;
   logic [IW-1:0] push_idx;
   logic [IW-1:0] pop_idx;
   logic [AW-1:0] stack [DEPTH];

   // Next-address candidates and stack bookkeeping
   always_comb begin
      op       = na_op_e'(NA_SEL);
      t        = COND[CS] ^ POL;
      inc      = CAR + AW'(1);
      map_addr = AW'(32'(MAP_BASE) + 32'({OPCODE, 2'b00}));
      full     = (SP == SW'(DEPTH));
      empty    = (SP == '0);
      push_idx = IW'(SP);
      pop_idx  = IW'(SP - SW'(1));
      push     = RST && !HALTED && !STALL && (op == OP_CALL) && t && !full;
   end

   // Return stack storage; contents need no reset
   always_ff @(posedge CLK) begin
      if (push) stack[push_idx] <= inc;
   end

   // Control address register, stack pointer and sticky flags
   always_ff @(posedge CLK) begin
      if (!RST) begin
         CAR     <= '0;
         SP      <= '0;
         HALTED  <= 1'b0;
         STK_ERR <= 1'b0;
      end else if (HALTED || STALL) begin
         CAR     <= CAR;
      end else begin
         case (op)
            OP_NEXT: CAR <= inc;
            OP_JMP:  CAR <= BR_ADDR;
            OP_BR:   CAR <= t ? BR_ADDR : inc;
            OP_MAP:  CAR <= map_addr;
            OP_CALL: begin
               if (t && !full) begin
                  CAR <= BR_ADDR;
                  SP  <= SP + SW'(1);
               end else begin
                  CAR <= inc;
                  if (t) STK_ERR <= 1'b1;
               end
            end
            OP_RET: begin
               if (!empty) begin
                  CAR <= stack[pop_idx];
                  SP  <= SP - SW'(1);
               end else begin
                  CAR     <= '0;
                  STK_ERR <= 1'b1;
               end
            end
            OP_HALT: HALTED <= 1'b1;
            OP_FETCH: begin
               CAR <= '0;
               SP  <= '0;
            end
            default: CAR <= inc;
         endcase
      end
   end

endmodule

// File: tb/tb_micro_seq.sv
// Directed-vector bench for micro_seq: each record gives the inputs for one
// clock edge and the CAR/SP/HALTED/STK_ERR values expected just after it.
module tb_micro_seq;

   logic       CLK = 1'b0;
   logic       RST;
   logic [2:0] NA_SEL;
   logic [2:0] CS;
   logic       POL;
   logic [7:0] BR_ADDR;
   logic [3:0] OPCODE;
   logic [7:0] COND;
   logic       STALL;
   logic [7:0] CAR;
   logic       HALTED;
   logic       STK_ERR;
   logic [2:0] SP;

   int checks   = 0;
   int failures = 0;

   micro_seq dut (
      .CLK(CLK), .RST(RST), .NA_SEL(NA_SEL), .CS(CS), .POL(POL),
      .BR_ADDR(BR_ADDR), .OPCODE(OPCODE), .COND(COND), .STALL(STALL),
      .CAR(CAR), .HALTED(HALTED), .STK_ERR(STK_ERR), .SP(SP)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string      name;
      logic       rst;
      logic [2:0] na;
      logic [2:0] cs;
      logic       pol;
      logic [7:0] br;
      logic [3:0] op;
      logic [7:0] cond;
      logic       stall;
      logic [7:0] car;
      logic [2:0] sp;
      logic       halted;
      logic       err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(string name, logic rst, logic [2:0] na,
                               logic [2:0] cs, logic pol, logic [7:0] br,
                               logic [3:0] op, logic [7:0] cond, logic stall,
                               logic [7:0] car, logic [2:0] sp,
                               logic halted, logic err);
      vec_t v;
      v.name = name; v.rst = rst; v.na = na; v.cs = cs; v.pol = pol;
      v.br = br; v.op = op; v.cond = cond; v.stall = stall;
      v.car = car; v.sp = sp; v.halted = halted; v.err = err;
      return v;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic run_vec(vec_t v);
      RST = v.rst; NA_SEL = v.na; CS = v.cs; POL = v.pol; BR_ADDR = v.br;
      OPCODE = v.op; COND = v.cond; STALL = v.stall;
      @(posedge CLK);
      #1;
      chk({v.name, ".car"},    32'(CAR),     32'(v.car));
      chk({v.name, ".sp"},     32'(SP),      32'(v.sp));
      chk({v.name, ".halted"}, 32'(HALTED),  32'(v.halted));
      chk({v.name, ".err"},    32'(STK_ERR), 32'(v.err));
   endtask

   initial begin
      RST = 1'b0; NA_SEL = 3'd0; CS = 3'd0; POL = 1'b0; BR_ADDR = 8'h00;
      OPCODE = 4'h0; COND = 8'h01; STALL = 1'b0;

      //            name          rst na cs pol br     op    cond   st  car    sp  h  e
      vecs.push_back(mk("rst0",     0, 0, 0, 0, 8'h00, 4'h0, 8'h01, 0, 8'h00, 0, 0, 0));
      vecs.push_back(mk("rst1",     0, 0, 0, 0, 8'h00, 4'h0, 8'h01, 0, 8'h00, 0, 0, 0));
      vecs.push_back(mk("seq1",     1, 0, 0, 0, 8'h00, 4'h0, 8'h01, 0, 8'h01, 0, 0, 0));
      vecs.push_back(mk("seq2",     1, 0, 0, 0, 8'h00, 4'h0, 8'h01, 0, 8'h02, 0, 0, 0));
      vecs.push_back(mk("seq3",     1, 0, 0, 0, 8'h00, 4'h0, 8'h01, 0, 8'h03, 0, 0, 0));
      vecs.push_back(mk("seq4",     1, 0, 0, 0, 8'h00, 4'h0, 8'h01, 0, 8'h04, 0, 0, 0));
      vecs.push_back(mk("seq5",     1, 0, 0, 0, 8'h00, 4'h0, 8'h01, 0, 8'h05, 0, 0, 0));
      vecs.push_back(mk("jmp3a",    1, 1, 0, 0, 8'h03, 4'h0, 8'h01, 0, 8'h03, 0, 0, 0));
      vecs.push_back(mk("br_taken", 1, 2, 1, 0, 8'h20, 4'h0, 8'h03, 0, 8'h20, 0, 0, 0));
      vecs.push_back(mk("jmp3b",    1, 1, 0, 0, 8'h03, 4'h0, 8'h03, 0, 8'h03, 0, 0, 0));
      vecs.push_back(mk("br_inv",   1, 2, 1, 1, 8'h20, 4'h0, 8'h03, 0, 8'h04, 0, 0, 0));
      vecs.push_back(mk("map5",     1, 3, 0, 0, 8'h00, 4'h5, 8'h01, 0, 8'h54, 0, 0, 0));
      vecs.push_back(mk("mapF",     1, 3, 0, 0, 8'h00, 4'hF, 8'h01, 0, 8'h7C, 0, 0, 0));
      vecs.push_back(mk("call_nt",  1, 4, 1, 0, 8'h99, 4'h0, 8'h01, 0, 8'h7D, 0, 0, 0));
      vecs.push_back(mk("jmp10",    1, 1, 0, 0, 8'h10, 4'h0, 8'h01, 0, 8'h10, 0, 0, 0));
      vecs.push_back(mk("call30",   1, 4, 0, 0, 8'h30, 4'h0, 8'h01, 0, 8'h30, 1, 0, 0));
      vecs.push_back(mk("call50",   1, 4, 0, 0, 8'h50, 4'h0, 8'h01, 0, 8'h50, 2, 0, 0));
      vecs.push_back(mk("ret31",    1, 5, 0, 0, 8'h00, 4'h0, 8'h01, 0, 8'h31, 1, 0, 0));
      vecs.push_back(mk("ret11",    1, 5, 0, 0, 8'h00, 4'h0, 8'h01, 0, 8'h11, 0, 0, 0));
      vecs.push_back(mk("ret_uf",   1, 5, 0, 0, 8'h00, 4'h0, 8'h01, 0, 8'h00, 0, 0, 1));
      vecs.push_back(mk("rst_clr",  0, 0, 0, 0, 8'h00, 4'h0, 8'h01, 0, 8'h00, 0, 0, 0));
      vecs.push_back(mk("callA0_1", 1, 4, 0, 0, 8'hA0, 4'h0, 8'h01, 0, 8'hA0, 1, 0, 0));
      vecs.push_back(mk("callA0_2", 1, 4, 0, 0, 8'hA0, 4'h0, 8'h01, 0, 8'hA0, 2, 0, 0));
      vecs.push_back(mk("callA0_3", 1, 4, 0, 0, 8'hA0, 4'h0, 8'h01, 0, 8'hA0, 3, 0, 0));
      vecs.push_back(mk("callA0_4", 1, 4, 0, 0, 8'hA0, 4'h0, 8'h01, 0, 8'hA0, 4, 0, 0));
      vecs.push_back(mk("call_ovf", 1, 4, 0, 0, 8'hA0, 4'h0, 8'h01, 0, 8'hA1, 4, 0, 1));

      foreach (vecs[i]) run_vec(vecs[i]);

      // Stall holds everything even with a JMP presented
      for (int i = 0; i < 3; i++)
         run_vec(mk("stall", 1, 1, 0, 0, 8'h55, 4'h0, 8'h01, 1, 8'hA1, 4, 0, 1));
      run_vec(mk("ret_after_stall", 1, 5, 0, 0, 8'h00, 4'h0, 8'h01, 0, 8'hA1, 3, 0, 1));
      run_vec(mk("fetch",           1, 7, 0, 0, 8'h00, 4'h0, 8'h01, 0, 8'h00, 0, 0, 1));

      // Address wrap, then halt with inputs churning
      run_vec(mk("jmpFF",  1, 1, 0, 0, 8'hFF, 4'h0, 8'h01, 0, 8'hFF, 0, 0, 1));
      run_vec(mk("wrap",   1, 0, 0, 0, 8'h00, 4'h0, 8'h01, 0, 8'h00, 0, 0, 1));
      run_vec(mk("jmp07",  1, 1, 0, 0, 8'h07, 4'h0, 8'h01, 0, 8'h07, 0, 0, 1));
      run_vec(mk("halt",   1, 6, 0, 0, 8'h00, 4'h0, 8'h01, 0, 8'h07, 0, 1, 1));
      for (int i = 0; i < 10; i++)
         run_vec(mk("halt_hold", 1, 3'(i), 3'(i), i[1], 8'(8'hE0 + i), 4'(i),
                    8'hFF, i[0], 8'h07, 0, 1, 1));
      run_vec(mk("rst_halt", 0, 4, 0, 0, 8'hA0, 4'h0, 8'h01, 0, 8'h00, 0, 0, 0));
      run_vec(mk("resume",   1, 0, 0, 0, 8'h00, 4'h0, 8'h01, 0, 8'h01, 0, 0, 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
